// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential instruction fetch stage with a small prefetch queue.
//
// Keeps at most one request in flight to a variable-latency instruction
// memory. Returned words are queued together with their PC in a DEPTH-entry
// FIFO that feeds decode. Flush and interrupt both redirect fetch, empty the
// queue and squash a response that is still in flight.
//
// Ports
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   mem_req / mem_addr       one-cycle request strobe and its fetch address
//   mem_rvalid / mem_rdata   response strobe and word (1+ cycles after mem_req)
//   stall                    decode cannot take the head entry this cycle
//   flush / redirect_pc      redirect fetch to redirect_pc (highest priority)
//   int_req                  level interrupt request
//   int_ack / epc            taken pulse and captured return PC
//   instr_valid / instr      head entry valid / head word (NOP_INSTR if empty)
//   instr_pc / pc_next       PC of the head entry and that PC + 4
//
// Decode handshake: instr_valid=1 offers the head entry; it is consumed on
// any cycle where instr_valid=1 and stall=0, except a flush or interrupt
// cycle, which discards the whole queue instead. While stall=1 the offered
// instr, instr_pc and pc_next hold.

module fetch_prefetch #(
    parameter int               XLEN      = 32,
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_2000,
    parameter logic [XLEN-1:0]  INT_VEC   = 32'h0000_1000,
    parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0800_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            int_req,
    output logic            int_ack,
    output logic [XLEN-1:0] epc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_next
);

    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;        // PC of the request currently in flight
    logic            outstanding;
    logic            discard;       // in-flight response belongs to a squashed path
    logic            taken;         // interrupt already taken for this int_req level

    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic            fifo_empty;
    logic            take_int;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [CW:0]     in_use;
    logic            has_credit;
    logic            issue;
    logic            rsp_accept;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] epc_sel;

    assign fifo_empty      = (count == '0);

    // rst_n gates the combinational strobes so they read 0 while reset is held.
    assign take_int        = rst_n & int_req & ~flush & ~taken;
    assign redirect        = flush | take_int;
    assign redirect_target = flush ? redirect_pc : INT_VEC;

    // The in-flight request reserves a slot so its response always fits.
    assign in_use          = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign has_credit      = (in_use < (CW+1)'(DEPTH));
    assign issue           = rst_n & ~outstanding & has_credit & ~redirect;

    assign rsp_accept      = mem_rvalid & outstanding;
    assign push            = rsp_accept & ~discard & ~redirect;
    assign pop             = ~fifo_empty & ~stall & ~redirect;

    // Return PC: oldest instruction not yet handed to decode. A squashed
    // in-flight request does not count.
    always_comb begin
        epc_sel = fetch_pc;
        if (!fifo_empty) begin
            epc_sel = fifo_pc[rd_ptr];
        end else if (outstanding && !discard) begin
            epc_sel = req_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            taken       <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            epc         <= '0;
        end else begin
            if (redirect) begin
                fetch_pc    <= redirect_target;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                // A response landing in this cycle retires the request here;
                // otherwise it is still coming and must be thrown away.
                outstanding <= outstanding & ~mem_rvalid;
                discard     <= outstanding & ~mem_rvalid;
            end else begin
                if (issue) begin
                    fetch_pc    <= fetch_pc + PC_STEP;
                    req_pc      <= fetch_pc;
                    outstanding <= 1'b1;
                end else if (rsp_accept) begin
                    outstanding <= 1'b0;
                end
                if (rsp_accept) begin
                    discard <= 1'b0;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
            if (take_int) begin
                epc <= epc_sel;
            end
            taken <= int_req & (taken | take_int);
        end
    end

    // Queue storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= mem_rdata;
        end
    end

    assign mem_req     = issue;
    assign mem_addr    = fetch_pc;
    assign int_ack     = take_int;
    assign instr_valid = ~fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : fifo_instr[rd_ptr];
    assign instr_pc    = fifo_empty ? '0 : fifo_pc[rd_ptr];
    assign pc_next     = instr_pc + PC_STEP;

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised fetch stage with a prefetch queue. It generates sequential instruction addresses, keeps at most one request outstanding to a variable-latency instruction memory, and buffers returned words with their PCs in a DEPTH-entry FIFO. It sits between the instruction memory system and decode. It adds flush/redirect with squash of in-flight responses, interrupt vectoring with return-PC capture, and a valid/stall handshake toward decode.

## Interface
- XLEN, 32, address and instruction width
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2
- RESET_PC, 32'h0000_2000, first fetch address after reset
- INT_VEC, 32'h0000_1000, interrupt handler address
- NOP_INSTR, 32'h0800_0000, word driven on instr when instr_valid=0
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  out  1  request strobe, one cycle per request
- mem_addr  out  XLEN  request address, valid with mem_req
- mem_rvalid  in  1  response valid; arrives 1 or more cycles after mem_req
- mem_rdata  in  XLEN  response word
- stall  in  1  decode cannot accept this cycle
- flush  in  1  redirect fetch to redirect_pc
- redirect_pc  in  XLEN  target PC, sampled when flush=1
- int_req  in  1  level interrupt request
- int_ack  out  1  one-cycle pulse when the interrupt is taken
- epc  out  XLEN  return PC captured when the interrupt is taken
- instr_valid  out  1  head of FIFO valid
- instr  out  XLEN  head instruction, or NOP_INSTR when not valid
- instr_pc  out  XLEN  PC of head instruction
- pc_next  out  XLEN  instr_pc + 4 (modulo 2^XLEN)

## Operation
- State:
  - fetch_pc
  - FIFO of {pc, instr} with count
  - outstanding bit
  - discard bit
  - int_pending-taken latch
- Issue: mem_req=1 when outstanding=0 and count+outstanding<DEPTH and no flush or interrupt redirect this cycle.
  - mem_addr=fetch_pc.
  - Sets outstanding; fetch_pc+=4, wrapping at 2^XLEN.
- Response: mem_rvalid clears outstanding.
  - If discard=1: the word is dropped and discard is cleared.
  - Otherwise push {pc of request, mem_rdata}.
  - mem_rvalid while outstanding=0 is ignored.
- Decode handshake: pop when instr_valid=1 and stall=0.
  - Push and pop in the same cycle leave count unchanged.
  - instr, instr_pc and pc_next hold while stalled.
- Flush (highest priority):
  - FIFO emptied.
  - fetch_pc=redirect_pc.
  - If a request is outstanding and its response is not arriving this cycle, set discard.
  - A response arriving in the flush cycle is dropped.
  - stall is ignored in the flush cycle.
- Interrupt: taken when int_req=1, flush=0, and not already taken since int_req last went low.
  - epc = head pc if FIFO non-empty, else pc of the outstanding request if any, else fetch_pc.
  - Then behaves exactly as a flush to INT_VEC; int_ack pulses.
  - The taken latch clears when int_req=0.
  - When flush and int_req coincide, the flush wins and the interrupt is taken in the next cycle with flush=0.
- Only one request is ever in flight, so responses are in order by construction.

## Timing
- Reset values:
  - mem_req=0, mem_addr=RESET_PC
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0, pc_next=4
  - int_ack=0, epc=0
  - FIFO empty; outstanding=0, discard=0, taken=0
  - fetch_pc=RESET_PC
- First mem_req is in the first clk edge cycle after rst_n deasserts.
- Response accepted in cycle N gives instr_valid=1 in cycle N+1 when the FIFO was empty.
- Back-to-back issue: the next mem_req is possible in the cycle after mem_rvalid.
- Flush or interrupt in cycle N:
  - instr_valid=0 in N+1.
  - mem_req with the new target in N+1 unless discard is set; otherwise in the cycle after the discarded response.
- int_ack is asserted in the cycle the interrupt is taken; epc is updated at the same edge and holds until the next interrupt.
- rst_n low mid-operation forces all reset values asynchronously.
  - A response arriving after reset with outstanding=0 is ignored.
- Full FIFO: count+outstanding=DEPTH blocks issue; a pop frees one credit the next cycle.

## Test plan
- Reset, 1-cycle memory, stall=0:
  - mem_addr sequence 0x2000, 0x2004, 0x2008.
  - instr_pc follows the same sequence; pc_next = instr_pc+4.
  - instr = NOP_INSTR before the first valid.
- DEPTH=4, stall held high for 20 cycles:
  - Exactly 4 requests issued, then mem_req stays 0.
  - instr and instr_pc are stable at 0x2000.
  - Releasing stall drains the entries in order with no gaps.
- 3-cycle memory latency, flush with redirect_pc=0x3000 one cycle after a mem_req:
  - The late response is dropped.
  - The next mem_addr is 0x3000.
  - The first valid instr_pc is 0x3000.
- FIFO holding 0x2008, 0x200C; int_req raised:
  - int_ack pulses once and epc=0x2008.
  - The next mem_addr is 0x1000.
  - No second ack while int_req stays high.
- flush and int_req in the same cycle:
  - The redirect to redirect_pc happens first.
  - int_ack the next cycle, with epc=redirect_pc.
- Wrap: redirect_pc=0xFFFF_FFFC gives a next fetch of 0x0000_0000 and pc_next=0 for that instruction.
- rst_n pulsed low mid-burst:
  - Outputs return to reset values immediately.
  - Fetch restarts at 0x2000.
